// File: rtl/alu_out_stage.sv
// ALU output stage: two-entry result FIFO with stored zero/negative/parity flags
// and a delivered-result counter.
module alu_out_stage #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RESULT,
  input  logic [2:0]       OPSEL,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [2:0]       OUT_OP,
  output logic             FLAG_Z,
  output logic             FLAG_N,
  output logic             FLAG_P,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [7:0]       TXCNT
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [2:0]       op;
    logic             z;
    logic             n;
    logic             p;
  } entry_t;

  state_t state;
  state_t next_state;
  entry_t mem [2];
  entry_t incoming;
  entry_t head;
  logic   wptr;
  logic   rptr;
  logic   push;
  logic   pop;
  logic [7:0] txcnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= EMPTY;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      EMPTY: if (push) next_state = ONE;
      ONE: begin
        if (push && !pop)      next_state = FULL;
        else if (pop && !push) next_state = EMPTY;
      end
      FULL: if (pop) next_state = ONE;
      default: next_state = EMPTY;
    endcase
  end

  // Handshake flags depend on registered state only.
  always_comb begin
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    unique case (state)
      EMPTY: IN_READY = 1'b1;
      ONE: begin
        IN_READY  = 1'b1;
        OUT_VALID = 1'b1;
      end
      FULL: OUT_VALID = 1'b1;
      default: IN_READY = 1'b0;
    endcase
  end

  assign push = IN_VALID && IN_READY;
  assign pop  = OUT_VALID && OUT_READY;

  always_comb begin
    incoming.data = RESULT;
    incoming.op   = OPSEL;
    incoming.z    = (RESULT == '0);
    incoming.n    = RESULT[WIDTH-1];
    incoming.p    = ^RESULT;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wptr    <= 1'b0;
      rptr    <= 1'b0;
      txcnt_q <= 8'd0;
    end else begin
      if (push) begin
        mem[wptr] <= incoming;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr    <= ~rptr;
        txcnt_q <= txcnt_q + 8'd1;
      end
    end
  end

  // Empty queue presents zeros instead of stale contents.
  assign head = OUT_VALID ? mem[rptr] : '0;

  assign OUT_DATA = head.data;
  assign OUT_OP   = head.op;
  assign FLAG_Z   = head.z;
  assign FLAG_N   = head.n;
  assign FLAG_P   = head.p;
  assign TXCNT    = txcnt_q;

endmodule

// File: tb/tb_alu_out_stage.sv
// Bench for alu_out_stage: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_out_stage;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] RESULT;
  logic [2:0]   OPSEL;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] OUT_DATA;
  logic [2:0]   OUT_OP;
  logic         FLAG_Z;
  logic         FLAG_N;
  logic         FLAG_P;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [7:0]   TXCNT;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [W-1:0] d;
    logic [2:0]   op;
  } ent_t;

  ent_t q[$];
  int   m_tx = 0;

  alu_out_stage #(.WIDTH(W)) dut (
    .CLK(CLK),
    .RST(RST),
    .RESULT(RESULT),
    .OPSEL(OPSEL),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA),
    .OUT_OP(OUT_OP),
    .FLAG_Z(FLAG_Z),
    .FLAG_N(FLAG_N),
    .FLAG_P(FLAG_P),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .TXCNT(TXCNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
  endtask

  // Reference model: a bounded queue of at most two entries.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q.delete();
      m_tx = 0;
    end else begin
      bit do_push;
      bit do_pop;
      do_push = IN_VALID && (q.size() < 2);
      do_pop  = OUT_READY && (q.size() > 0);
      if (do_pop) begin
        void'(q.pop_front());
        m_tx = (m_tx + 1) % 256;
      end
      if (do_push) q.push_back('{RESULT, OPSEL});
    end
  end

  always @(negedge CLK) begin
    logic [W-1:0] ed;
    logic [2:0]   eo;
    ed = (q.size() > 0) ? q[0].d : '0;
    eo = (q.size() > 0) ? q[0].op : '0;
    check("cmp_in_ready", IN_READY, q.size() < 2);
    check("cmp_out_valid", OUT_VALID, q.size() > 0);
    check("cmp_data", OUT_DATA, ed);
    check("cmp_op", OUT_OP, eo);
    check("cmp_z", FLAG_Z, (q.size() > 0) && (ed == 0));
    check("cmp_n", FLAG_N, ed[W-1]);
    check("cmp_p", FLAG_P, ^ed);
    check("cmp_txcnt", TXCNT, m_tx);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    step();
    step();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    RESULT = '0;
    OPSEL = '0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    do_reset();
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_in_ready", IN_READY, 1);
    check("rst_txcnt", TXCNT, 0);

    // single pass of a zero result
    IN_VALID = 1'b1; RESULT = 16'h0000; OPSEL = 3'd3; OUT_READY = 1'b1;
    step();
    IN_VALID = 1'b0;
    check("sp_valid", OUT_VALID, 1);
    check("sp_data", OUT_DATA, 16'h0000);
    check("sp_op", OUT_OP, 3);
    check("sp_flags", {FLAG_Z, FLAG_N, FLAG_P}, 3'b100);
    step();
    check("sp_valid_after", OUT_VALID, 0);
    check("sp_txcnt", TXCNT, 1);

    // backpressure: third push must be dropped
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; RESULT = 16'h8001; OPSEL = 3'd1;
    step();
    RESULT = 16'h00FF; OPSEL = 3'd2;
    step();
    check("bp_in_ready", IN_READY, 0);
    RESULT = 16'h1234; OPSEL = 3'd5;
    step();
    IN_VALID = 1'b0;
    check("bp_head", OUT_DATA, 16'h8001);
    check("bp_head_flags", {FLAG_Z, FLAG_N, FLAG_P}, 3'b010);
    OUT_READY = 1'b1;
    step();
    check("bp_second", OUT_DATA, 16'h00FF);
    check("bp_second_op", OUT_OP, 2);
    check("bp_second_flags", {FLAG_Z, FLAG_N, FLAG_P}, 3'b000);
    step();
    check("bp_drained", OUT_VALID, 0);
    check("bp_txcnt", TXCNT, 3);

    // push and pop together while holding one entry
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; RESULT = 16'h0001; OPSEL = 3'd4;
    step();
    check("pp_hold_p", FLAG_P, 1);
    RESULT = 16'h0003; OPSEL = 3'd6; OUT_READY = 1'b1;
    step();
    IN_VALID = 1'b0;
    check("pp_valid", OUT_VALID, 1);
    check("pp_in_ready", IN_READY, 1);
    check("pp_data", OUT_DATA, 16'h0003);
    check("pp_p", FLAG_P, 0);
    step();
    check("pp_txcnt", TXCNT, 5);

    // 256 back-to-back transfers wrap the counter
    do_reset();
    OUT_READY = 1'b1;
    for (int j = 0; j < 256; j++) begin
      IN_VALID = 1'b1; RESULT = W'(j); OPSEL = 3'(j);
      step();
      check("wr_in_ready", IN_READY, 1);
      check("wr_order", OUT_DATA, j);
    end
    IN_VALID = 1'b0;
    step();
    check("wr_empty", OUT_VALID, 0);
    check("wr_txcnt", TXCNT, 0);

    // asynchronous reset while full
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; RESULT = 16'hABCD; OPSEL = 3'd7;
    step();
    RESULT = 16'h5555;
    step();
    IN_VALID = 1'b0;
    check("ar_full", IN_READY, 0);
    #2 RST = 1'b1;
    #1;
    check("ar_valid", OUT_VALID, 0);
    check("ar_in_ready", IN_READY, 1);
    check("ar_data", OUT_DATA, 0);
    check("ar_op", OUT_OP, 0);
    check("ar_flags", {FLAG_Z, FLAG_N, FLAG_P}, 3'b000);
    check("ar_txcnt", TXCNT, 0);
    #2 RST = 1'b0;
    IN_VALID = 1'b1; RESULT = 16'h7E00; OPSEL = 3'd2;
    step();
    IN_VALID = 1'b0;
    check("ar_first_push", OUT_VALID, 1);
    check("ar_first_data", OUT_DATA, 16'h7E00);
    step();

    // randomized traffic with occasional mid-run reset
    for (int i = 0; i < 3000; i++) begin
      int pick;
      pick = $urandom_range(0, 9);
      RST = ($urandom_range(0, 249) == 0);
      IN_VALID = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 2) != 0);
      OPSEL = 3'($urandom);
      if (pick == 0)      RESULT = '0;
      else if (pick == 1) RESULT = 16'h8000;
      else if (pick == 2) RESULT = 16'hFFFF;
      else                RESULT = W'($urandom);
      step();
    end
    RST = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    step();
    step();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
